// File: rtl/ex_mdu_if.sv
// ID/EX-side bundle for the iterative multiply/divide unit: operand inputs
// from the pipeline register and write-back/stall outputs back to the core.
interface ex_mdu_if;
    logic [31:0] inst_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [4:0]  rd_addr_i;
    logic        reg_wen_i;
    logic        hold_req_o;
    logic        busy_o;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr_o;
    logic        reg_wen_o;

    modport master (
        output inst_i,
        output op1_i,
        output op2_i,
        output rd_addr_i,
        output reg_wen_i,
        input  hold_req_o,
        input  busy_o,
        input  rd_data_o,
        input  rd_addr_o,
        input  reg_wen_o
    );

    modport slave (
        input  inst_i,
        input  op1_i,
        input  op2_i,
        input  rd_addr_i,
        input  reg_wen_i,
        output hold_req_o,
        output busy_o,
        output rd_data_o,
        output rd_addr_o,
        output reg_wen_o
    );
endinterface

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring
// divide on operand magnitudes, with a single-cycle fast path for div-by-zero/overflow.
module ex_mdu (
    input  logic    clk,
    input  logic    rst_n,
    ex_mdu_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [4:0]  r_cnt;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd_addr;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_acc;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_divisor;
    logic [31:0] r_result;

    logic [2:0]  w_funct3;
    logic        w_is_m;
    logic        w_start;
    logic        w_is_div;
    logic        w_op1_signed;
    logic        w_op2_signed;
    logic        w_sign1;
    logic        w_sign2;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic        w_div_zero;
    logic        w_overflow;
    logic        w_fast;
    logic [31:0] w_fast_result;
    logic        w_last_iter;

    logic [63:0] w_acc_next;
    logic [32:0] w_shifted;
    logic [32:0] w_diff;
    logic [32:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_remd;
    logic [31:0] w_final;
    logic        w_unused;

    // Register-index fields travel separately on rd_addr_i; only opcode/funct fields decode.
    assign w_unused = ^{bus.inst_i[24:15], bus.inst_i[11:7]};

    assign w_funct3 = bus.inst_i[14:12];
    assign w_is_m   = (bus.inst_i[6:0] == 7'b0110011) && (bus.inst_i[31:25] == 7'b0000001);
    assign w_start  = w_is_m & bus.reg_wen_i & (r_state == StIdle);
    assign w_is_div = w_funct3[2];

    always_comb begin
        w_op1_signed = 1'b0;
        w_op2_signed = 1'b0;
        unique case (w_funct3)
            3'b001: begin
                w_op1_signed = 1'b1;
                w_op2_signed = 1'b1;
            end
            3'b010: w_op1_signed = 1'b1;
            3'b100, 3'b110: begin
                w_op1_signed = 1'b1;
                w_op2_signed = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_sign1 = w_op1_signed & bus.op1_i[31];
    assign w_sign2 = w_op2_signed & bus.op2_i[31];
    assign w_mag1  = w_sign1 ? (32'd0 - bus.op1_i) : bus.op1_i;
    assign w_mag2  = w_sign2 ? (32'd0 - bus.op2_i) : bus.op2_i;

    assign w_div_zero = w_is_div & (bus.op2_i == 32'd0);
    assign w_overflow = w_is_div & ~w_funct3[0] & (bus.op1_i == 32'h8000_0000)
                        & (bus.op2_i == 32'hFFFF_FFFF);
    assign w_fast     = w_div_zero | w_overflow;

    always_comb begin
        w_fast_result = 32'd0;
        if (w_funct3[1]) begin
            w_fast_result = w_div_zero ? bus.op1_i : 32'd0;
        end else begin
            w_fast_result = w_div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
        end
    end

    // One multiplier bit per cycle, LSB first, against a left-shifting multiplicand.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 64'd0);

    // Restoring step: bring in the next dividend bit, keep the difference if non-negative.
    assign w_shifted  = {r_rem[31:0], r_quo[31]};
    assign w_diff     = w_shifted - {1'b0, r_divisor};
    assign w_rem_next = w_diff[32] ? w_shifted : w_diff;
    assign w_quo_next = {r_quo[30:0], ~w_diff[32]};

    assign w_prod = r_neg_res ? (64'd0 - w_acc_next) : w_acc_next;
    assign w_quot = r_neg_res ? (32'd0 - w_quo_next) : w_quo_next;
    assign w_remd = r_neg_rem ? (32'd0 - w_rem_next[31:0]) : w_rem_next[31:0];

    always_comb begin
        w_final = 32'd0;
        unique case (r_funct3)
            3'b000:                 w_final = w_prod[31:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod[63:32];
            3'b100, 3'b101:         w_final = w_quot;
            default:                w_final = w_remd;
        endcase
    end

    assign w_last_iter = (r_cnt == 5'd31);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_next = w_fast ? StDone : StRun;
                end
            end
            StRun: begin
                if (w_last_iter) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_cnt     <= 5'd0;
            r_funct3  <= 3'd0;
            r_rd_addr <= 5'd0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_mcand   <= 64'd0;
            r_mplier  <= 32'd0;
            r_acc     <= 64'd0;
            r_rem     <= 33'd0;
            r_quo     <= 32'd0;
            r_divisor <= 32'd0;
            r_result  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_cnt     <= 5'd0;
                        r_funct3  <= w_funct3;
                        r_rd_addr <= bus.rd_addr_i;
                        r_neg_res <= w_sign1 ^ w_sign2;
                        r_neg_rem <= w_sign1;
                        r_mcand   <= {32'd0, w_mag1};
                        r_mplier  <= w_mag2;
                        r_acc     <= 64'd0;
                        r_rem     <= 33'd0;
                        r_quo     <= w_mag1;
                        r_divisor <= w_mag2;
                        r_result  <= w_fast_result;
                    end
                end
                StRun: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_funct3[2]) begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= {r_mcand[62:0], 1'b0};
                        r_mplier <= {1'b0, r_mplier[31:1]};
                    end
                    if (w_last_iter) begin
                        r_result <= w_final;
                    end
                end
                default: ;
            endcase
        end
    end

    // A new M instruction arriving during DONE is stalled, not started.
    assign bus.hold_req_o = w_start | (r_state == StRun) | ((r_state == StDone) & w_is_m);
    assign bus.busy_o     = (r_state == StRun);
    assign bus.reg_wen_o  = (r_state == StDone);
    assign bus.rd_data_o  = (r_state == StDone) ? r_result : 32'd0;
    assign bus.rd_addr_o  = (r_state == StDone) ? r_rd_addr : 5'd0;

endmodule
